// File: rtl/vx_warp_ibuffer.sv
// vx_warp_ibuffer: per-warp instruction FIFOs feeding one registered
// valid/ready output. The output warp is chosen round-robin among warps
// that hold entries, so a stalled warp cannot block the others.
// Optional build macro VX_IBUF_BYPASS_EN: when every FIFO is empty and the
// output register can load, an accepted instruction goes straight into the
// output register instead of through its FIFO.
module vx_warp_ibuffer #(
    parameter  int NUM_WARPS = 4,
    parameter  int DATAW     = 64,
    parameter  int DEPTH     = 2,
    localparam int NW_BITS   = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NW_BITS-1:0]   in_wid,
    input  logic [DATAW-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NW_BITS-1:0]   out_wid,
    output logic [DATAW-1:0]     out_data,
    output logic [NUM_WARPS-1:0] empty_mask
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [DATAW-1:0]     mem    [NUM_WARPS][DEPTH];
    logic [PTRW-1:0]      wr_ptr [NUM_WARPS];
    logic [PTRW-1:0]      rd_ptr [NUM_WARPS];
    logic [CNTW-1:0]      count  [NUM_WARPS];
    logic [NW_BITS-1:0]   rr;
    logic [NW_BITS-1:0]   pick;
    logic                 found;
    logic                 push_fire;
    logic                 push_en;
    logic                 pop_en;
    logic                 load_en;
    logic                 bypass;
    logic [NUM_WARPS-1:0] push_vec;
    logic [NUM_WARPS-1:0] pop_vec;
    logic [31:0]          in_wid_ext;

    // A full warp stays not-ready even if it is popped this cycle.
    assign in_ready  = (count[in_wid] != CNTW'(DEPTH));
    assign push_fire = in_valid & in_ready;
    assign load_en   = ~out_valid | out_ready;

`ifdef VX_IBUF_BYPASS_EN
    assign bypass = push_fire & (&empty_mask) & load_en;
`else
    assign bypass = 1'b0;
`endif

    // Bypassed instructions never enter a FIFO.
    assign push_en = push_fire & ~bypass;
    assign pop_en  = load_en & found;

    // Per-warp empty flags, excluding the output register.
    always_comb begin
        empty_mask = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++)
            empty_mask[w] = (count[w] == '0);
    end

    // Round-robin pick: first non-empty warp scanning from rr upward.
    always_comb begin
        found = 1'b0;
        pick  = rr;
        for (int unsigned i = 0; i < NUM_WARPS; i++) begin
            if (!found && count[rr + NW_BITS'(i)] != '0) begin
                found = 1'b1;
                pick  = rr + NW_BITS'(i);
            end
        end
    end

    // Decode push/pop into per-warp strobes.
    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            push_vec[w] = push_en && (in_wid == NW_BITS'(w));
            pop_vec[w]  = pop_en && (pick == NW_BITS'(w));
        end
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                wr_ptr[w] <= '0;
                rd_ptr[w] <= '0;
                count[w]  <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                if (push_vec[w])
                    wr_ptr[w] <= wr_ptr[w] + PTRW'(1);
                if (pop_vec[w])
                    rd_ptr[w] <= rd_ptr[w] + PTRW'(1);
                case ({push_vec[w], pop_vec[w]})
                    2'b10:   count[w] <= count[w] + CNTW'(1);
                    2'b01:   count[w] <= count[w] - CNTW'(1);
                    default: count[w] <= count[w];
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care while the count is zero.
    always_ff @(posedge clk) begin
        if (push_en)
            mem[in_wid][wr_ptr[in_wid]] <= in_data;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_wid   <= '0;
            out_data  <= '0;
            rr        <= '0;
        end else if (load_en) begin
            if (bypass) begin
                out_valid <= 1'b1;
                out_wid   <= in_wid;
                out_data  <= in_data;
                rr        <= in_wid + NW_BITS'(1);
            end else if (found) begin
                out_valid <= 1'b1;
                out_wid   <= pick;
                out_data  <= mem[pick][rd_ptr[pick]];
                rr        <= pick + NW_BITS'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign in_wid_ext = 32'(in_wid);

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        pop_en |-> (count[pick] != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        push_en |-> (count[in_wid] != CNTW'(DEPTH)));
    a_wid_range: assert property (@(posedge clk) disable iff (!reset)
        in_valid |-> (in_wid_ext < 32'(NUM_WARPS)));

endmodule
